// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: one-outstanding request with a ready strobe.
// The fetch stage is the master; the memory model or arbiter is the slave.
interface fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_data_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, one-entry skid buffer for stalls and
// a drop state that swallows the stale response left behind by a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fetch_stage_if.master        imem,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    output logic [31:0]          instr_o,
    output logic [31:0]          pc_plus4_o,
    output logic                 valid_o
);

    typedef enum logic [1:0] {StFetch, StFull, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;

        unique case (state_q)
            StFetch: begin
                if (imem.imem_ready_i) begin
                    pc_d = pc_inc;
                    if (!stall_i) begin
                        instr_d = imem.imem_data_i;
                        pc4_d   = pc_inc;
                        valid_d = 1'b1;
                    end else begin
                        buf_instr_d = imem.imem_data_i;
                        buf_pc4_d   = pc_inc;
                        state_d     = StFull;
                    end
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                end
            end
            StFull: begin
                if (!stall_i) begin
                    instr_d = buf_instr_q;
                    pc4_d   = buf_pc4_q;
                    valid_d = 1'b1;
                    state_d = StFetch;
                end
            end
            StDrop: begin
                if (imem.imem_ready_i) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        // Redirect wins over stall and over any response arriving this cycle.
        if (redirect_i) begin
            pc_d        = redirect_pc_i & 32'hFFFF_FFFC;
            instr_d     = instr_q;
            pc4_d       = pc4_q;
            valid_d     = 1'b0;
            buf_instr_d = 32'h0;
            buf_pc4_d   = 32'h0;
            if (state_q != StFull && !imem.imem_ready_i) begin
                state_d = StDrop;
                if (state_q == StFetch) begin
                    drop_addr_d = pc_q;
                end
            end else begin
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            drop_addr_q <= 32'h0;
            instr_q     <= 32'h0;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
            buf_instr_q <= 32'h0;
            buf_pc4_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
        end
    end

    assign imem.imem_req_o  = !rst_i && (state_q != StFull);
    assign imem.imem_addr_o = (state_q == StDrop) ? drop_addr_q : pc_q;
    assign instr_o          = instr_q;
    assign pc_plus4_o       = pc4_q;
    assign valid_o          = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr>>2, a scoreboard checks
// every instruction the decoder consumes, plus point checks on handshake state.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ready = 1'b1;

    logic [31:0] instr_a, pc4_a, instr_b, pc4_b;
    logic        valid_a, valid_b;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_word;
    logic [31:0] exp_b_instr [3];
    logic [31:0] exp_b_pc4 [3];

    fetch_stage_if imem_a ();
    fetch_stage_if imem_b ();

    assign imem_a.imem_ready_i = ready;
    assign imem_a.imem_data_i  = imem_a.imem_addr_o >> 2;
    assign imem_b.imem_ready_i = 1'b1;
    assign imem_b.imem_data_i  = imem_b.imem_addr_o >> 2;

    fetch_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem          (imem_a),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_o       (instr_a),
        .pc_plus4_o    (pc4_a),
        .valid_o       (valid_a)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem          (imem_b),
        .stall_i       (1'b0),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .instr_o       (instr_b),
        .pc_plus4_o    (pc4_b),
        .valid_o       (valid_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr);
        exp_q.push_back({addr >> 2, addr + 32'd4});
    endtask

    // Decoder consumes IF/ID when it is valid, not stalled and not being flushed.
    always @(negedge clk) begin
        if (!rst && valid_a && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_underflow observed=%0h expected=none", instr_a);
            end else begin
                exp_word = exp_q.pop_front();
                chk("sb_instr", instr_a, exp_word[63:32]);
                chk("sb_pc4", pc4_a, exp_word[31:0]);
            end
        end
    end

    initial begin
        exp_b_instr[0] = 32'h3FFF_FFFE; exp_b_pc4[0] = 32'hFFFF_FFFC;
        exp_b_instr[1] = 32'h3FFF_FFFF; exp_b_pc4[1] = 32'h0000_0000;
        exp_b_instr[2] = 32'h0000_0000; exp_b_pc4[2] = 32'h0000_0004;

        tick(); tick(); tick();
        chk("rst_valid", {31'h0, valid_a}, 32'h0);
        chk("rst_instr", instr_a, 32'h0);
        chk("rst_pc4", pc4_a, 32'h0);
        chk("rst_req", {31'h0, imem_a.imem_req_o}, 32'h0);

        for (int k = 0; k < 7; k++) push(32'(4 * k));
        rst = 1'b0;
        #1;
        chk("c0_req", {31'h0, imem_a.imem_req_o}, 32'h1);
        chk("c0_addr", imem_a.imem_addr_o, 32'h0);
        chk("c0_wrap_addr", imem_b.imem_addr_o, 32'hFFFF_FFF8);

        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("run_valid", {31'h0, valid_a}, 32'h1);
            chk("run_addr", imem_a.imem_addr_o, 32'(4 * k));
            if (k <= 3) begin
                chk("wrap_instr", instr_b, exp_b_instr[k-1]);
                chk("wrap_pc4", pc4_b, exp_b_pc4[k-1]);
            end
        end

        // IF/ID holds 0x10's instruction; stall for four cycles.
        stall = 1'b1;
        tick();
        chk("stall_req", {31'h0, imem_a.imem_req_o}, 32'h0);
        chk("stall_hold", instr_a, 32'h4);
        tick(); tick(); tick();
        chk("stall_req_late", {31'h0, imem_a.imem_req_o}, 32'h0);
        chk("stall_hold_late", instr_a, 32'h4);
        stall = 1'b0;
        tick();
        chk("release_instr", instr_a, 32'h5);
        chk("release_req", {31'h0, imem_a.imem_req_o}, 32'h1);
        chk("release_addr", imem_a.imem_addr_o, 32'h18);
        tick();
        chk("nobubble_valid", {31'h0, valid_a}, 32'h1);
        chk("nobubble_instr", instr_a, 32'h6);

        // Memory ready once every third cycle.
        push(32'h1C); push(32'h20); push(32'h24);
        for (int j = 0; j < 9; j++) begin
            chk("wait_valid", {31'h0, valid_a}, (j % 3 == 0) ? 32'h1 : 32'h0);
            chk("wait_addr", imem_a.imem_addr_o, 32'h1C + 32'(4 * (j / 3)));
            ready = (j % 3 == 2);
            tick();
        end
        chk("wait_end_instr", instr_a, 32'h9);
        chk("wait_end_pc4", pc4_a, 32'h28);

        // Redirect while a request is pending: stale response must be dropped.
        ready = 1'b0;
        tick();
        chk("pend_valid", {31'h0, valid_a}, 32'h0);
        chk("pend_addr", imem_a.imem_addr_o, 32'h28);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        chk("drop_req", {31'h0, imem_a.imem_req_o}, 32'h1);
        chk("drop_addr", imem_a.imem_addr_o, 32'h28);
        chk("drop_valid", {31'h0, valid_a}, 32'h0);
        tick();
        chk("drop_addr_hold", imem_a.imem_addr_o, 32'h28);
        push(32'h100);
        ready = 1'b1;
        tick();
        chk("redir_addr", imem_a.imem_addr_o, 32'h100);
        chk("redir_valid", {31'h0, valid_a}, 32'h0);
        tick();
        chk("redir_instr", instr_a, 32'h40);
        chk("redir_pc4", pc4_a, 32'h104);

        // Redirect and stall together while the skid buffer is full.
        tick();
        stall = 1'b1;
        tick();
        chk("full_req", {31'h0, imem_a.imem_req_o}, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        chk("flush_valid", {31'h0, valid_a}, 32'h0);
        chk("flush_addr", imem_a.imem_addr_o, 32'h200);
        push(32'h200); push(32'h204);
        tick();
        chk("flush_instr", instr_a, 32'h80);
        tick();
        chk("flush_instr2", instr_a, 32'h81);
        tick();
        stall = 1'b1;
        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register feeding the instruction decoder. Holds the PC, issues one-outstanding-request reads to instruction memory through a req/ready handshake, and presents `instr_o[31:26]` straight to the decoder's opcode input. It absorbs stalls with a one-entry skid buffer and discards fetches on redirect (taken branch, jump, jr), so the decoder only ever sees valid, in-order instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset; must be word aligned.
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `imem_req_o`  output  1  read request to instruction memory.
- `imem_addr_o`  output  32  word-aligned read address; stable while `imem_req_o`=1 and `imem_ready_i`=0.
- `imem_ready_i`  input  1  response strobe; `imem_data_i` valid this cycle; may be high in the same cycle as the request.
- `imem_data_i`  input  32  instruction word.
- `stall_i`  input  1  hold the IF/ID register (load-use hazard from downstream).
- `redirect_i`  input  1  flush and restart fetch at `redirect_pc_i`.
- `redirect_pc_i`  input  32  new PC; bits [1:0] ignored (treated as 0).
- `instr_o`  output  32  IF/ID instruction; `[31:26]` drive the decoder opcode.
- `pc_plus4_o`  output  32  IF/ID address of instruction + 4.
- `valid_o`  output  1  IF/ID holds a real instruction; 0 = bubble.

## Operation
- Registers: `pc`, IF/ID {`instr_o`, `pc_plus4_o`, `valid_o`}, skid buffer {`buf_instr`, `buf_pc4`}, state.
- States: FETCH (request outstanding at `pc`), FULL (buffer occupied, no request), DROP (stale request outstanding, response to be discarded).
- `imem_req_o` = 1 in FETCH and DROP, 0 in FULL and whenever `rst_i`=1. `imem_addr_o` = `pc` in FETCH; in DROP it holds the stale address (see below).
- FETCH, `imem_ready_i`=1, `stall_i`=0: IF/ID <= {`imem_data_i`, `pc`+4, 1}; `pc` <= `pc`+4; stay FETCH.
- FETCH, `imem_ready_i`=1, `stall_i`=1: buffer <= {`imem_data_i`, `pc`+4}; `pc` <= `pc`+4; go FULL; IF/ID unchanged.
- FETCH, `imem_ready_i`=0: if `stall_i`=0, `valid_o` <= 0 (bubble; `instr_o`/`pc_plus4_o` unchanged). If `stall_i`=1, IF/ID unchanged.
- FULL, `stall_i`=0: IF/ID <= {`buf_instr`, `buf_pc4`, 1}; go FETCH. FULL, `stall_i`=1: hold everything.
- DROP: the old address is kept in a separate `drop_addr` register; `pc` already holds the redirect target. On `imem_ready_i`=1, discard data and go FETCH. IF/ID `valid_o` stays 0.
- Redirect (highest priority, overrides `stall_i` and any response this cycle): `pc` <= {`redirect_pc_i`[31:2], 2'b00}; `valid_o` <= 0; buffer cleared.
  - Next state: DROP if in FETCH or DROP with `imem_ready_i`=0, since a request is still outstanding. Otherwise FETCH.
- Reset: `pc`=`RESET_PC`, state FETCH, `valid_o`=0, `instr_o`=0, `pc_plus4_o`=0, buffer cleared. `rst_i` mid-transaction abandons any outstanding request; memory must tolerate this.
- Arithmetic: `pc`+4 is 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

## Timing
- First request is asserted in the first cycle with `rst_i`=0, at `RESET_PC`.
- With `imem_ready_i` tied high: a fetch issued in cycle N gives `valid_o`=1 with that instruction in N+1. Throughput is one instruction per cycle.
- Stall release from FULL: buffered instruction appears the next cycle; the new request issues that same cycle, so there is no bubble with zero-wait memory.
- Redirect in cycle N: `valid_o`=0 in N+1. With zero-wait memory, the first redirected instruction is valid in N+2.
- At most one outstanding request; no new request while one is in flight, except that DROP completes the stale one first.

## Test plan
- Reset release, `imem_ready_i`=1, memory returns addr>>2 as data: `valid_o`=1 from cycle 1 with `instr_o`=0,1,2,..., `pc_plus4_o`=4,8,12,...
- Wait states (ready every 3rd cycle): `valid_o` pulses 1 once per 3 cycles; `imem_addr_o` never changes while req=1 and ready=0.
- `stall_i` high for 4 cycles at addr 0x10: IF/ID holds 0x10's instr, one further fetch (0x14) is buffered, req drops. Release gives 0x14 next cycle, then 0x18 with no bubble.
- `redirect_i`=1, `redirect_pc_i`=0x103 while request pending with ready=0: DROP, stale response discarded, next fetch at 0x100, `valid_o`=0 until 0x100 arrives.
- Redirect and stall simultaneous while FULL: buffer cleared, `valid_o`=0, fetch resumes at the target.
- `RESET_PC`=32'hFFFF_FFF8: fetches FFF8, FFFC, 0000; `pc_plus4_o` = FFFC, 0000, 0004.
